// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive engine. Receives the 8N1-style frames that uart_core transmits:
// the asynchronous line is synchronised, a falling edge starts a frame, the
// start bit is re-checked half a bit later, DATA_WIDTH data bits are sampled
// mid-bit LSB first, and the stop bit is checked. Good bytes land in a
// one-entry valid/ready output buffer.
//
// Handshake: a byte is transferred on every clock edge where
// rx_valid_o & rx_ready_i. While rx_valid_o is high and rx_ready_i is low,
// rx_valid_o and rx_data_o hold their values.
//
// Ports
//   main_clk_i    in   1           clock
//   main_rst_i    in   1           synchronous, active-high reset
//   ena_i         in   1           receiver enable; low aborts any frame
//   div_i         in   DIV_WIDTH   clocks per bit (values below 4 act as 4)
//   uart_rx_i     in   1           serial line, idle high, asynchronous
//   rx_data_o     out  DATA_WIDTH  received byte
//   rx_valid_o    out  1           rx_data_o holds an unconsumed byte
//   rx_ready_i    in   1           consumer accepts the byte this cycle
//   busy_o        out  1           a frame is being received
//   frame_err_o   out  1           one-cycle pulse: stop bit sampled low
//   overrun_o     out  1           one-cycle pulse: byte dropped, buffer full
//   dbg_state_o   out  2           current FSM state (IDLE/START/DATA/STOP)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_i,
  input  logic                  ena_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  uart_rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic [1:0]            dbg_state_o
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect. Flops reset to 1 so an idle
  // line coming out of reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rxs;
  logic                   w_fall;

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
      r_prev <= w_rxs;
    end
  end

  assign w_rxs  = r_sync[SYNC_STAGES-1];
  assign w_fall = r_prev & ~w_rxs;

  // ---------------------------------------------------------------------------
  // Bit timing. The divisor is captured when a frame starts so a register
  // write in the middle of a frame cannot distort it.
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_half_last;
  logic [DIV_WIDTH-1:0] w_bit_last;

  assign w_div_eff   = (div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_i;
  assign w_half_last = (r_div >> 1) - DIV_WIDTH'(1);
  assign w_bit_last  = r_div - DIV_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Receive FSM plus output buffer, all registered.
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_div       <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumer side of the buffer; a delivery below overrides this clear.
      if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end

      if (!ena_i) begin
        // Disable aborts silently; the buffer keeps working.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Edge, not level: a line held low (break) never restarts.
            if (w_fall) begin
              r_state <= S_START;
              r_cnt   <= '0;
              r_div   <= w_div_eff;
            end
          end

          S_START: begin
            if (r_cnt == w_half_last) begin
              r_cnt <= '0;
              r_bit <= '0;
              // Line back high at mid start bit: a glitch, drop it quietly.
              r_state <= w_rxs ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end

          S_DATA: begin
            if (r_cnt == w_bit_last) begin
              r_cnt          <= '0;
              r_shreg[r_bit] <= w_rxs;
              if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                r_state <= S_STOP;
              end else begin
                r_bit <= r_bit + BIT_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end

          S_STOP: begin
            if (r_cnt == w_bit_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
              if (!w_rxs) begin
                r_frame_err <= 1'b1;
              end else if (!r_valid || rx_ready_i) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int DW  = 8;
  localparam int DVW = 16;
  localparam int SS  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [DVW-1:0] div;
  logic           rx_pin;
  logic           rx_ready;
  logic [DW-1:0]  rx_data;
  logic           rx_valid;
  logic           busy;
  logic           ferr;
  logic           ovr;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW), .SYNC_STAGES(SS)) dut (
    .main_clk_i  (clk),
    .main_rst_i  (rst),
    .ena_i       (ena),
    .div_i       (div),
    .uart_rx_i   (rx_pin),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .busy_o      (busy),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_div(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks. The serial line changes on negedges; ready and reset change
  // 2 time units after a posedge so the negedge monitor never races them.
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [DW-1:0] data, input int d, input bit stop_bit,
                            input bit chk_busy);
    logic [DW+1:0] bits;
    bits = {stop_bit, data, 1'b0};
    @(negedge clk);
    for (int i = 0; i < DW + 2; i++) begin
      rx_pin = bits[i];
      for (int c = 1; c <= d; c++) begin
        @(negedge clk);
        if (chk_busy && i > 0 && c == d / 2) check("busy_in_frame", busy, 1);
      end
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    rx_ready = v;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  rx_data,  0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_ferr"},  ferr,     0);
    check({tag, "_ovr"},   ovr,      0);
  endtask

  // Random consumer: ready toggles 1 time unit after posedge when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops the expected queue on every accepted byte, counts error
  // pulses, and checks that a stalled byte is held.
  // ---------------------------------------------------------------------------
  initial begin
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", rx_valid, 1);
          check("hold_data", rx_data, prev_data);
        end
        if (ferr) n_ferr++;
        if (ovr)  n_ovr++;
        if (ferr || ovr) check("err_exclusive", ferr & ovr, 0);
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", rx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", rx_data, e);
          end
        end
        prev_hold = rx_valid && !rx_ready;
        prev_data = rx_data;
      end
    end
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    int ferr0;
    int ovr0;
    int d;
    logic [DW-1:0] data;

    rst      = 1'b1;
    ena      = 1'b1;
    div      = DVW'(16);
    rx_pin   = 1'b1;
    rx_ready = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 at 16 clocks/bit, ready low: latency and held output
    exp_q.push_back(8'hA5);
    cyc = 0;
    fork
      send_frame(8'hA5, 16, 1'b1, 1'b1);
      begin
        wait (rx_pin == 1'b0);
        while (!rx_valid && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    n_total++;
    if (cyc < 152 || cyc > 162) begin
      n_bad++;
      $display("FAIL valid_latency: got %0d cycles expected 152..162", cyc);
    end
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    repeat (10) @(negedge clk);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("a5_accepted", rx_valid, 0);
    set_ready(1'b0);

    // 0x01 then 0xFF with ready low: one overrun, first byte kept
    ovr0 = n_ovr;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 16, 1'b1, 1'b1);
    send_frame(8'hFF, 16, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_count", n_ovr - ovr0, 1);
    check("ovr_data_kept", rx_data, 8'h01);
    check("ovr_valid", rx_valid, 1);
    @(posedge clk);
    #2;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop_next", rx_valid, 0);

    // Stop bit low on 0x55, then line held low for 40 bit times
    ferr0 = n_ferr;
    send_frame(8'h55, 16, 1'b0, 1'b1);
    repeat (40 * 16) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_count", n_ferr - ferr0, 1);
    check("ferr_no_valid", rx_valid, 0);
    check("break_idle", busy, 0);

    // 3-clock glitch
    ferr0 = n_ferr;
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idle", busy, 0);
    check("glitch_no_valid", rx_valid, 0);
    check("glitch_no_err", n_ferr - ferr0, 0);

    // div_i=2 behaves as 4 clocks/bit
    div = DVW'(2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 4, 1'b1, 1'b1);
    wait_drain("div2_drain");

    // Enable dropped mid-frame
    div  = DVW'(16);
    ferr0 = n_ferr;
    ovr0  = n_ovr;
    fork
      send_frame(8'hC3, 16, 1'b1, 1'b0);
      begin
        repeat (3 * 16) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ena_abort_busy", busy, 0);
      end
    join
    repeat (20) @(negedge clk);
    ena = 1'b1;
    repeat (10) @(negedge clk);
    check("ena_no_valid", rx_valid, 0);
    check("ena_no_err", (n_ferr - ferr0) + (n_ovr - ovr0), 0);

    // Back-to-back 0x12, 0x34 with ready high
    ovr0 = n_ovr;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 16, 1'b1, 1'b1);
    send_frame(8'h34, 16, 1'b1, 1'b1);
    wait_drain("b2b_drain");
    check("b2b_no_ovr", n_ovr - ovr0, 0);

    // Reset during DATA while a byte is buffered, then clean 0x3C
    set_ready(1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 16, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("pre_rst_valid", rx_valid, 1);
    fork
      send_frame(8'hFF, 16, 1'b1, 1'b0);
      begin
        repeat (48) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    set_ready(1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b1);
    wait_drain("post_rst_drain");

    // Randomised frames, random consumer, divisor changed mid-frame
    ovr0 = n_ovr;
    ferr0 = n_ferr;
    rand_ready = 1'b1;
    div = DVW'($urandom_range(0, 20));
    for (int f = 0; f < 16; f++) begin
      d    = eff_div(int'(div));
      data = DW'($urandom);
      exp_q.push_back(data);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      fork
        send_frame(data, d, 1'b1, 1'b1);
        begin
          repeat (d * 4) @(negedge clk);
          div = DVW'($urandom_range(0, 20));
        end
      join
    end
    wait_drain("rand_drain");
    rand_ready = 1'b0;
    set_ready(1'b1);
    check("rand_no_ovr", n_ovr - ovr0, 0);
    check("rand_no_ferr", n_ferr - ferr0, 0);

    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
